// File: rtl/seq_nonrestoring_divider_if.sv
`default_nettype none
// ============================================================================
//  Module   : seq_nonrestoring_divider_if
//  Purpose  : Request/response bundle between the control unit and the
//             sequential non-restoring divider.
//  Revision : 1.0 - initial release
// ============================================================================
interface seq_nonrestoring_divider_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             overflow;

  // Control unit side: issues requests, consumes results.
  modport master (
    output start, signed_op, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, overflow
  );

  // Divider side: accepts requests, produces results.
  modport slave (
    input  start, signed_op, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, overflow
  );
endinterface
`default_nettype wire

// File: rtl/seq_nonrestoring_divider.sv
`default_nettype none
// ============================================================================
//  Module   : seq_nonrestoring_divider
//  Purpose  : Multi-cycle signed/unsigned non-restoring integer divider,
//             one quotient bit per clock, with divide-by-zero and signed
//             overflow flags and a start/busy/done handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_nonrestoring_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  wire logic                   clock,
  input  wire logic                   clear,
  seq_nonrestoring_divider_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    ITER = 2'd2,
    FIX  = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] MIN_VAL   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES  = {WIDTH{1'b1}};
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_t             state, state_next;

  // Operands latched at the accept edge so the inputs may change afterwards.
  logic [WIDTH-1:0]   dvd, dvs;
  logic               sop;

  // AQ holds the (WIDTH+1)-bit partial remainder A above the WIDTH-bit Q.
  logic [2*WIDTH:0]   aq;
  logic [WIDTH:0]     mag_m;
  logic               q_neg, r_neg;
  logic [CNT_W-1:0]   cnt;

  logic               done_r, dz_r, ov_r;
  logic [WIDTH-1:0]   quot_r, rem_r;

  logic [WIDTH-1:0]   dvd_mag, dvs_mag;
  logic [WIDTH:0]     a_sh, a_new, a_fix;
  logic [2*WIDTH:0]   aq_step;
  logic [WIDTH-1:0]   q_mag, quot_fix, rem_fix;
  logic               is_ovf;

  // Operand magnitudes; MIN maps to 2**(WIDTH-1), which is correct unsigned.
  assign dvd_mag = (sop && dvd[WIDTH-1]) ? -dvd : dvd;
  assign dvs_mag = (sop && dvs[WIDTH-1]) ? -dvs : dvs;

  // One non-restoring step. The add/subtract choice uses the sign of A
  // before the shift, so transient wrap of the shifted value cancels out.
  assign a_sh    = aq[2*WIDTH-1:WIDTH-1];
  assign a_new   = aq[2*WIDTH] ? (a_sh + mag_m) : (a_sh - mag_m);
  assign aq_step = {a_new, aq[WIDTH-2:0], ~a_new[WIDTH]};

  // Final remainder restore and sign correction.
  assign a_fix    = aq[2*WIDTH] ? (aq[2*WIDTH:WIDTH] + mag_m) : aq[2*WIDTH:WIDTH];
  assign q_mag    = aq[WIDTH-1:0];
  assign quot_fix = q_neg ? -q_mag : q_mag;
  assign rem_fix  = r_neg ? -a_fix[WIDTH-1:0] : a_fix[WIDTH-1:0];
  assign is_ovf   = sop && (dvd == MIN_VAL) && (dvs == ALL_ONES);

  assign bus.busy        = (state != IDLE);
  assign bus.done        = done_r;
  assign bus.quotient    = quot_r;
  assign bus.remainder   = rem_r;
  assign bus.div_by_zero = dz_r;
  assign bus.overflow    = ov_r;

  // State register.
  always_ff @(posedge clock) begin
    if (clear) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = PREP;
      PREP:    state_next = (dvs == '0) ? IDLE : ITER;
      ITER:    if (cnt == LAST_STEP) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration and result registers.
  always_ff @(posedge clock) begin
    if (clear) begin
      dvd    <= '0;
      dvs    <= '0;
      sop    <= 1'b0;
      aq     <= '0;
      mag_m  <= '0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      cnt    <= '0;
      done_r <= 1'b0;
      dz_r   <= 1'b0;
      ov_r   <= 1'b0;
      quot_r <= '0;
      rem_r  <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            dvd <= bus.dividend;
            dvs <= bus.divisor;
            sop <= bus.signed_op;
          end
        end
        PREP: begin
          if (dvs == '0) begin
            quot_r <= ALL_ONES;
            rem_r  <= dvd;
            dz_r   <= 1'b1;
            ov_r   <= 1'b0;
            done_r <= 1'b1;
          end else begin
            aq    <= {{(WIDTH+1){1'b0}}, dvd_mag};
            mag_m <= {1'b0, dvs_mag};
            q_neg <= sop & (dvd[WIDTH-1] ^ dvs[WIDTH-1]);
            r_neg <= sop & dvd[WIDTH-1];
            cnt   <= '0;
          end
        end
        ITER: begin
          aq  <= aq_step;
          cnt <= cnt + CNT_W'(1);
        end
        FIX: begin
          quot_r <= is_ovf ? MIN_VAL : quot_fix;
          rem_r  <= is_ovf ? '0 : rem_fix;
          ov_r   <= is_ovf;
          dz_r   <= 1'b0;
          done_r <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_nonrestoring_divider.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_nonrestoring_divider
//  Purpose  : Directed self-checking bench for seq_nonrestoring_divider.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_nonrestoring_divider;

  logic clock = 1'b0;
  logic clear = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  seq_nonrestoring_divider_if #(.WIDTH(32)) bus ();

  seq_nonrestoring_divider #(.WIDTH(32), .CNT_W(6)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Issue one request and check latency, busy/done behaviour and results.
  // Latency counts edges after the accept edge until done is visible.
  task automatic run_div(input string name, input logic sop,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_q, input logic [31:0] exp_r,
                         input logic exp_dz, input logic exp_ov, input int exp_lat);
    int  lat;
    bit  got;
    lat = 0;
    got = 0;
    @(negedge clock);
    bus.start     = 1'b1;
    bus.signed_op = sop;
    bus.dividend  = a;
    bus.divisor   = b;
    @(posedge clock);
    #1;
    bus.start    = 1'b0;
    bus.dividend = ~a;
    bus.divisor  = ~b;
    check({name, "_busy_on"}, 64'(bus.busy), 64'd1);
    while (!got && lat < 100) begin
      @(posedge clock);
      #1;
      lat++;
      if (bus.done) got = 1;
    end
    check({name, "_done_seen"}, 64'(got), 64'd1);
    check({name, "_latency"}, 64'(lat), 64'(exp_lat));
    check({name, "_busy_at_done"}, 64'(bus.busy), 64'd0);
    check({name, "_q"}, 64'(bus.quotient), 64'(exp_q));
    check({name, "_r"}, 64'(bus.remainder), 64'(exp_r));
    check({name, "_dz"}, 64'(bus.div_by_zero), 64'(exp_dz));
    check({name, "_ov"}, 64'(bus.overflow), 64'(exp_ov));
    @(posedge clock);
    #1;
    check({name, "_done_pulse"}, 64'(bus.done), 64'd0);
    check({name, "_q_hold"}, 64'(bus.quotient), 64'(exp_q));
  endtask

  initial begin
    int seen_done;
    int dn;
    bus.start     = 1'b0;
    bus.signed_op = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;

    repeat (3) @(posedge clock);
    #1;
    clear = 1'b0;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_q", 64'(bus.quotient), 64'd0);
    check("rst_r", 64'(bus.remainder), 64'd0);
    check("rst_dz", 64'(bus.div_by_zero), 64'd0);
    check("rst_ov", 64'(bus.overflow), 64'd0);

    run_div("u100_7",    1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 1'b0, 34);
    run_div("s-100_7",   1'b1, 32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0, 1'b0, 34);
    run_div("s100_-7",   1'b1, 32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   32'd2,          1'b0, 1'b0, 34);
    run_div("s-1_2",     1'b1, 32'hFFFFFFFF,   32'd2,          32'd0,          32'hFFFFFFFF,   1'b0, 1'b0, 34);
    run_div("s-7_-2",    1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   32'd3,          32'hFFFFFFFF,   1'b0, 1'b0, 34);
    run_div("uffff_2",   1'b0, 32'hFFFFFFFF,   32'd2,          32'h7FFFFFFF,   32'd1,          1'b0, 1'b0, 34);
    run_div("uffff_fffe",1'b0, 32'hFFFFFFFF,   32'hFFFFFFFE,   32'd1,          32'd1,          1'b0, 1'b0, 34);
    run_div("u123_0",    1'b0, 32'd123,        32'd0,          32'hFFFFFFFF,   32'd123,        1'b1, 1'b0, 1);
    run_div("smin_-1",   1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0, 1'b1, 34);

    // Abort 1000/3 part-way through the iterations.
    @(negedge clock);
    bus.start     = 1'b1;
    bus.signed_op = 1'b0;
    bus.dividend  = 32'd1000;
    bus.divisor   = 32'd3;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    repeat (12) @(posedge clock);
    @(negedge clock);
    clear = 1'b1;
    @(posedge clock);
    #1;
    clear = 1'b0;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_q", 64'(bus.quotient), 64'd0);
    check("abort_r", 64'(bus.remainder), 64'd0);
    check("abort_ov", 64'(bus.overflow), 64'd0);
    check("abort_dz", 64'(bus.div_by_zero), 64'd0);
    seen_done = 0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (bus.done) seen_done++;
    end
    check("abort_no_done", 64'(seen_done), 64'd0);
    run_div("u1000_3", 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 1'b0, 34);

    // start held for 40 edges with operands changing every cycle: accepts at
    // edges 0 and 35 (5000/7 -> 714 r 2, 5455/42 -> 129 r 37).
    dn = 0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      @(negedge clock);
      bus.start     = (cyc < 40);
      bus.signed_op = 1'b0;
      bus.dividend  = 32'(5000 + 13 * cyc);
      bus.divisor   = 32'(7 + cyc);
      @(posedge clock);
      #1;
      if (bus.done) begin
        if (dn == 0) begin
          check("b2b_edge0", 64'(cyc), 64'd34);
          check("b2b_q0", 64'(bus.quotient), 64'd714);
          check("b2b_r0", 64'(bus.remainder), 64'd2);
        end else begin
          check("b2b_edge1", 64'(cyc), 64'd69);
          check("b2b_q1", 64'(bus.quotient), 64'd129);
          check("b2b_r1", 64'(bus.remainder), 64'd37);
        end
        dn++;
      end
    end
    bus.start = 1'b0;
    check("b2b_count", 64'(dn), 64'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
